// File: rtl/bpd_pkg.sv
// Shared types and helpers for the bpd_tourn tournament direction predictor.
package bpd_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bpd_state_e;

  // One saturating step of a width-bit counter: up when dir, down otherwise.
  function automatic int unsigned satcnt_next(input int unsigned cnt,
                                              input logic        dir,
                                              input int unsigned width);
    int unsigned max_v;
    max_v = (32'd1 << width) - 32'd1;
    if (dir) return (cnt >= max_v) ? max_v : cnt + 32'd1;
    else     return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
  endfunction

  // Weak value just below the midpoint (weak not-taken / weak-local).
  function automatic int unsigned weak_init(input int unsigned width);
    return (32'd1 << (width - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bpd_tourn_sat_pht.sv
// sat_pht: table of saturating counters with a combinational lookup port,
// a read-modify-write update port and an init port that has priority.
module sat_pht
  import bpd_pkg::*;
#(
  parameter int DEPTH_LOG = 12,
  parameter int CNT_W     = 2
) (
  input  logic                 clock,
  input  logic [DEPTH_LOG-1:0] rd_idx_i,
  output logic [CNT_W-1:0]     rd_cnt_o,
  input  logic                 wr_en_i,
  input  logic [DEPTH_LOG-1:0] wr_idx_i,
  input  logic                 wr_inc_i,
  output logic [CNT_W-1:0]     wr_cnt_o,
  input  logic                 init_en_i,
  input  logic [DEPTH_LOG-1:0] init_idx_i
);

  localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'(weak_init(CNT_W));

  logic [CNT_W-1:0] mem_q [2**DEPTH_LOG];
  logic [CNT_W-1:0] wr_data_d;

  // Lookup and update-side reads see the pre-edge contents (no bypass).
  always_comb begin
    rd_cnt_o  = mem_q[rd_idx_i];
    wr_cnt_o  = mem_q[wr_idx_i];
    wr_data_d = CNT_W'(satcnt_next(32'(wr_cnt_o), wr_inc_i, CNT_W));
  end

  // Counter storage; the owner's init sweep writes every entry after reset.
  // NOTE: the array has no reset branch so it can map to RAM; the sweep initialises it.
  always_ff @(posedge clock) begin
    if (init_en_i)    mem_q[init_idx_i] <= INIT_VAL;
    else if (wr_en_i) mem_q[wr_idx_i]   <= wr_data_d;
  end

endmodule

// File: rtl/bpd_tourn.sv
// bpd_tourn: tournament (gshare + local + choice) direction predictor for F1.
// Optional performance counters are built when BPD_TOURN_PERF_CNT_EN is defined.
module bpd_tourn
  import bpd_pkg::*;
#(
  parameter int PC_W    = 64,
  parameter int GHIST_W = 12,
  parameter int LHIST_W = 10,
  parameter int GCNT_W  = 2,
  parameter int LCNT_W  = 3,
  parameter int CCNT_W  = 2
) (
  input  logic               clock,
  input  logic               reset,
  output logic               ready_o,
  input  logic               flush_i,
  input  logic               cond_br_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [PC_W-1:0]    pc_t_i,
  input  logic [PC_W-1:0]    pc_nt_i,
  input  logic [LHIST_W-1:0] lochist_i,
  input  logic               btb_dir_i,
  output logic               pred_o,
  output logic               gpred_o,
  output logic               lpred_o,
  output logic [GHIST_W-1:0] bhr_o,
  output logic               override_o,
  output logic [PC_W-1:0]    override_pc_o,
  input  logic               upd_valid_i,
  input  logic               upd_dir_i,
  input  logic [PC_W-1:0]    upd_pc_i,
  input  logic [GHIST_W-1:0] upd_bhr_i,
  input  logic [LHIST_W-1:0] upd_lochist_i,
  input  logic               upd_gpred_i,
  input  logic               upd_lpred_i,
`ifdef BPD_TOURN_PERF_CNT_EN
  output logic [31:0]        perf_lookup_o,
  output logic [31:0]        perf_mispred_o,
`endif
  input  logic               rec_valid_i
);

  bpd_state_e         state_q, state_d;
  logic [GHIST_W-1:0] init_idx_q, init_idx_d;
  logic [GHIST_W-1:0] bhr_q, bhr_d;
  logic [GHIST_W-1:0] gidx, ugidx;
  logic               run, init_en, upd_en, c_wr_en, c_inc;
  logic               gpred_raw, lpred_raw, pred_raw;
  logic [GCNT_W-1:0]  g_cnt, g_wcnt_unused;
  logic [LCNT_W-1:0]  l_cnt, l_wcnt_unused;
  logic [CCNT_W-1:0]  c_cnt, c_wcnt;
  logic               unused_bits;

  assign run     = (state_q == RUN);
  assign init_en = (state_q == INIT);
  assign ready_o = run;
  assign bhr_o   = bhr_q;

  // Zero-latency lookup; every output is forced quiet until the tables are valid.
  always_comb begin
    gidx          = pc_i[GHIST_W+1:2] ^ bhr_q;
    ugidx         = upd_pc_i[GHIST_W+1:2] ^ upd_bhr_i;
    gpred_raw     = g_cnt[GCNT_W-1];
    lpred_raw     = l_cnt[LCNT_W-1];
    pred_raw      = c_cnt[CCNT_W-1] ? gpred_raw : lpred_raw;
    gpred_o       = run & gpred_raw;
    lpred_o       = run & lpred_raw;
    pred_o        = run & pred_raw;
    override_o    = run & cond_br_i & (btb_dir_i ^ pred_raw);
    override_pc_o = pred_o ? pc_t_i : pc_nt_i;
    upd_en        = run & upd_valid_i;
    // The chooser only learns when the two components disagreed.
    c_wr_en       = upd_en & (upd_gpred_i ^ upd_lpred_i);
    c_inc         = ~(upd_gpred_i ^ upd_dir_i);
  end

  sat_pht #(.DEPTH_LOG(GHIST_W), .CNT_W(GCNT_W)) u_gpht (
    .clock      (clock),
    .rd_idx_i   (gidx),
    .rd_cnt_o   (g_cnt),
    .wr_en_i    (upd_en),
    .wr_idx_i   (ugidx),
    .wr_inc_i   (upd_dir_i),
    .wr_cnt_o   (g_wcnt_unused),
    .init_en_i  (init_en),
    .init_idx_i (init_idx_q)
  );

  sat_pht #(.DEPTH_LOG(LHIST_W), .CNT_W(LCNT_W)) u_lpht (
    .clock      (clock),
    .rd_idx_i   (lochist_i),
    .rd_cnt_o   (l_cnt),
    .wr_en_i    (upd_en),
    .wr_idx_i   (upd_lochist_i),
    .wr_inc_i   (upd_dir_i),
    .wr_cnt_o   (l_wcnt_unused),
    .init_en_i  (init_en),
    .init_idx_i (init_idx_q[LHIST_W-1:0])
  );

  sat_pht #(.DEPTH_LOG(GHIST_W), .CNT_W(CCNT_W)) u_cpht (
    .clock      (clock),
    .rd_idx_i   (gidx),
    .rd_cnt_o   (c_cnt),
    .wr_en_i    (c_wr_en),
    .wr_idx_i   (ugidx),
    .wr_inc_i   (c_inc),
    .wr_cnt_o   (c_wcnt),
    .init_en_i  (init_en),
    .init_idx_i (init_idx_q)
  );

  // Next state: init sweep, then speculative history with recovery priority.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    bhr_d      = bhr_q;
    case (state_q)
      INIT: begin
        init_idx_d = init_idx_q + GHIST_W'(1);
        if (&init_idx_q) state_d = RUN;
      end
      RUN: begin
        if (flush_i) begin
          if (upd_valid_i)      bhr_d = {upd_bhr_i[GHIST_W-2:0], upd_dir_i};
          else if (rec_valid_i) bhr_d = upd_bhr_i;
        end else if (cond_br_i) begin
          bhr_d = {bhr_q[GHIST_W-2:0], pred_raw};
        end
      end
    endcase
  end

  // Control state registers; reset restarts the init sweep from index 0.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      bhr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      bhr_q      <= bhr_d;
    end
  end

`ifdef BPD_TOURN_PERF_CNT_EN
  logic [31:0] perf_lookup_q, perf_lookup_d;
  logic [31:0] perf_mispred_q, perf_mispred_d;
  logic        upd_pred;

  // Saturating lookup / mispredict counters, frozen while the sweep runs.
  always_comb begin
    upd_pred       = c_wcnt[CCNT_W-1] ? upd_gpred_i : upd_lpred_i;
    perf_lookup_d  = perf_lookup_q;
    perf_mispred_d = perf_mispred_q;
    if (run && cond_br_i && !(&perf_lookup_q))
      perf_lookup_d = perf_lookup_q + 32'd1;
    if (upd_en && (upd_pred != upd_dir_i) && !(&perf_mispred_q))
      perf_mispred_d = perf_mispred_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_lookup_q  <= '0;
      perf_mispred_q <= '0;
    end else begin
      perf_lookup_q  <= perf_lookup_d;
      perf_mispred_q <= perf_mispred_d;
    end
  end

  assign perf_lookup_o  = perf_lookup_q;
  assign perf_mispred_o = perf_mispred_q;
`endif

  // Index bits outside the hashed field and low counter bits are not needed.
  assign unused_bits = ^{pc_i[PC_W-1:GHIST_W+2], pc_i[1:0],
                         upd_pc_i[PC_W-1:GHIST_W+2], upd_pc_i[1:0],
                         g_cnt[GCNT_W-2:0], l_cnt[LCNT_W-2:0],
                         c_cnt[CCNT_W-2:0], c_wcnt};

endmodule

// File: tb/tb_bpd_tourn.sv
// Directed self-checking bench for bpd_tourn (default parameters).
module tb_bpd_tourn;

  logic        clock = 1'b0;
  logic        reset;
  logic        ready_o, flush_i, cond_br_i, btb_dir_i;
  logic [63:0] pc_i, pc_t_i, pc_nt_i, upd_pc_i, override_pc_o;
  logic [9:0]  lochist_i, upd_lochist_i;
  logic [11:0] bhr_o, upd_bhr_i;
  logic        pred_o, gpred_o, lpred_o, override_o;
  logic        upd_valid_i, upd_dir_i, upd_gpred_i, upd_lpred_i, rec_valid_i;
`ifdef BPD_TOURN_PERF_CNT_EN
  logic [31:0] perf_lookup_o, perf_mispred_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cnt;

  always #5 clock = ~clock;

  bpd_tourn dut (
    .clock         (clock),
    .reset         (reset),
    .ready_o       (ready_o),
    .flush_i       (flush_i),
    .cond_br_i     (cond_br_i),
    .pc_i          (pc_i),
    .pc_t_i        (pc_t_i),
    .pc_nt_i       (pc_nt_i),
    .lochist_i     (lochist_i),
    .btb_dir_i     (btb_dir_i),
    .pred_o        (pred_o),
    .gpred_o       (gpred_o),
    .lpred_o       (lpred_o),
    .bhr_o         (bhr_o),
    .override_o    (override_o),
    .override_pc_o (override_pc_o),
    .upd_valid_i   (upd_valid_i),
    .upd_dir_i     (upd_dir_i),
    .upd_pc_i      (upd_pc_i),
    .upd_bhr_i     (upd_bhr_i),
    .upd_lochist_i (upd_lochist_i),
    .upd_gpred_i   (upd_gpred_i),
    .upd_lpred_i   (upd_lpred_i),
`ifdef BPD_TOURN_PERF_CNT_EN
    .perf_lookup_o (perf_lookup_o),
    .perf_mispred_o(perf_mispred_o),
`endif
    .rec_valid_i   (rec_valid_i)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change here, away from the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    flush_i = 0; cond_br_i = 0; btb_dir_i = 0;
    pc_i = '0; lochist_i = '0;
    upd_valid_i = 0; upd_dir_i = 0; upd_pc_i = '0; upd_bhr_i = '0;
    upd_lochist_i = '0; upd_gpred_i = 0; upd_lpred_i = 0; rec_valid_i = 0;
  endtask

  task automatic set_upd(input logic [63:0] pc, input logic [11:0] bhr, input logic [9:0] lh,
                         input logic gp, input logic lp, input logic dir);
    upd_pc_i = pc; upd_bhr_i = bhr; upd_lochist_i = lh;
    upd_gpred_i = gp; upd_lpred_i = lp; upd_dir_i = dir;
  endtask

  // Wait (bounded) for ready_o; returns the number of rising edges spent.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready_o && n < 5000) begin
      step();
      n++;
    end
  endtask

  initial begin
    pc_t_i  = 64'hBBBB_0000;
    pc_nt_i = 64'hAAAA_0000;
    clear_inputs();
    reset = 1;
    #12;
    // Reset state, with a lookup that would otherwise request an override.
    cond_br_i = 1; btb_dir_i = 1;
    #1;
    check("rst_ready", ready_o, 0);
    check("rst_pred", pred_o, 0);
    check("rst_override", override_o, 0);
    check("rst_override_pc", override_pc_o, 64'hAAAA_0000);
    check("rst_bhr", bhr_o, 0);

    // Init sweep with recovery inputs asserted: they must be ignored.
    cond_br_i = 0; btb_dir_i = 0;
    flush_i = 1; rec_valid_i = 1; upd_bhr_i = 12'hFFF;
    reset = 0;
    wait_ready(cnt);
    check("init_cycles", cnt, 4096);
    check("init_ready", ready_o, 1);
    check("init_bhr_ignored", bhr_o, 0);
    clear_inputs();

    // Fresh tables predict not-taken everywhere.
    pc_i = 64'h1000; lochist_i = 10'h055; #1;
    check("fresh_gpred", gpred_o, 0);
    check("fresh_lpred", lpred_o, 0);
    check("fresh_pred", pred_o, 0);
    pc_i = 64'h2FFC; lochist_i = 10'h3FF; #1;
    check("fresh_pred_hi", pred_o, 0);

    // Two taken updates at pc 0x1000; first cycle reads the pre-update value.
    pc_i = 64'h1000; lochist_i = 10'h055;
    set_upd(64'h1000, 12'h000, 10'h055, 0, 0, 1);
    upd_valid_i = 1; #1;
    check("no_bypass_gpred", gpred_o, 0);
    step();
    check("one_upd_gpred", gpred_o, 1);
    step();
    upd_valid_i = 0; #1;
    check("train_gpred", gpred_o, 1);
    check("train_lpred", lpred_o, 1);
    check("train_pred", pred_o, 1);

    // Local counter saturation at both ends (3 -> 7 -> 4 -> 0 -> 3 -> 4).
    lochist_i = 10'h2AA;
    set_upd(64'h0, 12'h000, 10'h2AA, 0, 0, 1);
    upd_valid_i = 1; repeat (10) step();
    upd_valid_i = 0; #1;
    check("sat_hi_lpred", lpred_o, 1);
    upd_dir_i = 0; upd_valid_i = 1; repeat (3) step();
    upd_valid_i = 0; #1;
    check("sat_hi_nowrap", lpred_o, 1);
    upd_valid_i = 1; repeat (7) step();
    upd_valid_i = 0; #1;
    check("sat_lo_lpred", lpred_o, 0);
    upd_dir_i = 1; upd_valid_i = 1; repeat (3) step();
    upd_valid_i = 0; #1;
    check("sat_lo_nowrap", lpred_o, 0);
    upd_valid_i = 1; step();
    upd_valid_i = 0; #1;
    check("sat_lo_exact", lpred_o, 1);

    // History: restore 0x005, then shift in a taken prediction.
    flush_i = 1; rec_valid_i = 1; upd_bhr_i = 12'h005;
    step();
    flush_i = 0; rec_valid_i = 0; #1;
    check("rec_bhr_005", bhr_o, 12'h005);
    pc_i = 64'h3000; lochist_i = 10'h055; cond_br_i = 1; btb_dir_i = 0; #1;
    check("ovr_pred", pred_o, 1);
    check("ovr_req", override_o, 1);
    check("ovr_pc_taken", override_pc_o, 64'hBBBB_0000);
    step();
    cond_br_i = 0; #1;
    check("shift_bhr", bhr_o, 12'h00B);
    check("no_cond_no_ovr", override_o, 0);

    // BTB taken vs predicted not-taken, then flush with update beats everything.
    lochist_i = 10'h000; cond_br_i = 1; btb_dir_i = 1; #1;
    check("ovr_nt_req", override_o, 1);
    check("ovr_pc_nt", override_pc_o, 64'hAAAA_0000);
    flush_i = 1; rec_valid_i = 1; upd_valid_i = 1;
    set_upd(64'h0, 12'h800, 10'h100, 0, 0, 1);
    step();
    check("flush_upd_bhr", bhr_o, 12'h001);
    upd_valid_i = 0; upd_bhr_i = 12'h123;
    step();
    check("flush_rec_bhr", bhr_o, 12'h123);
    rec_valid_i = 0;
    step();
    check("flush_hold_bhr", bhr_o, 12'h123);
    clear_inputs();

    // Chooser: global taken vs local not-taken; one disagreement flips to global.
    flush_i = 1; rec_valid_i = 1; upd_bhr_i = 12'h000;
    step();
    clear_inputs();
    pc_i = 64'h1000; lochist_i = 10'h000; #1;
    check("chs_bhr0", bhr_o, 0);
    check("chs_gpred", gpred_o, 1);
    check("chs_lpred", lpred_o, 0);
    check("chs_pre_pred", pred_o, 0);
    set_upd(64'h1000, 12'h000, 10'h300, 1, 0, 1);
    upd_valid_i = 1;
    step();
    upd_valid_i = 0; #1;
    check("chs_post_pred", pred_o, 1);

    // Mid-run reset: leave a nonzero history, then restart the sweep.
    flush_i = 1; rec_valid_i = 1; upd_bhr_i = 12'h0AB;
    step();
    clear_inputs();
    check("pre_rst_bhr", bhr_o, 12'h0AB);
    #2 reset = 1; #1;
    check("mid_rst_ready", ready_o, 0);
    check("mid_rst_bhr", bhr_o, 0);
    #2 reset = 0;
    wait_ready(cnt);
    check("reinit_cycles", cnt, 4096);
    pc_i = 64'h1000; lochist_i = 10'h055; #1;
    check("reinit_gpred", gpred_o, 0);
    check("reinit_lpred", lpred_o, 0);
    check("reinit_pred", pred_o, 0);
    lochist_i = 10'h000; #1;
    check("reinit_choice", pred_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
